ace_snoop_initiator: RTL and testbench

//  Initiator (interconnect-side) end of the ACE snoop channels: issues one AC snoop request, then collects
//  the CR response and the optional CD cache-line data. Reports latency and protocol errors for

---
 rtl/ace_snoop_pkg.sv | 34 +++
 rtl/ace_cd_beat_collector.sv | 54 +++++
 rtl/ace_snoop_initiator.sv | 200 ++++++++++++++++++++
 tb/tb_ace_snoop_initiator.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ace_snoop_pkg.sv
// Shared types and constants for the ACE snoop initiator: FSM states, ACSNOOP encodings,
// CRRESP bit positions and status bit positions.
package ace_snoop_pkg;

  typedef enum logic [2:0] {S_IDLE, S_AC, S_CR, S_CD, S_DONE} state_e;

  localparam logic [3:0] ACSNOOP_READ_ONCE             = 4'h0;
  localparam logic [3:0] ACSNOOP_READ_SHARED           = 4'h1;
  localparam logic [3:0] ACSNOOP_READ_CLEAN            = 4'h2;
  localparam logic [3:0] ACSNOOP_READ_NOT_SHARED_DIRTY = 4'h3;
  localparam logic [3:0] ACSNOOP_READ_UNIQUE           = 4'h7;
  localparam logic [3:0] ACSNOOP_CLEAN_SHARED          = 4'h8;
  localparam logic [3:0] ACSNOOP_CLEAN_INVALID         = 4'h9;
  localparam logic [3:0] ACSNOOP_MAKE_INVALID          = 4'hD;
  localparam logic [3:0] ACSNOOP_DVM_COMPLETE          = 4'hE;
  localparam logic [3:0] ACSNOOP_DVM_MESSAGE           = 4'hF;

  localparam int unsigned CRRESP_DATA_TRANSFER = 0;
  localparam int unsigned CRRESP_ERROR         = 1;
  localparam int unsigned CRRESP_PASS_DIRTY    = 2;
  localparam int unsigned CRRESP_IS_SHARED     = 3;
  localparam int unsigned CRRESP_WAS_UNIQUE    = 4;

  localparam int unsigned STATUS_W            = 4;
  localparam int unsigned STATUS_TIMEOUT      = 0;
  localparam int unsigned STATUS_EARLY_LAST   = 1;
  localparam int unsigned STATUS_MISSING_LAST = 2;
  localparam int unsigned STATUS_UNSOLICITED  = 3;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ace_cd_beat_collector.sv
// Collects CD beats into a cache-line buffer and flags CDLAST placement errors.
module ace_cd_beat_collector #(
  parameter int unsigned DataWidth = 128,
  parameter int unsigned Beats     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         beat_hs_i,
  input  logic [DataWidth-1:0]         cddata_i,
  input  logic                         cdlast_i,
  output logic [Beats*DataWidth-1:0]   line_o,
  output logic                         complete_o,
  output logic                         err_early_o,
  output logic                         err_missing_o
);

  localparam int unsigned CntW = (Beats > 1) ? $clog2(Beats) : 1;

  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [Beats*DataWidth-1:0] line_q, line_d;
  logic                       is_final;

  always_comb begin
    is_final      = (cnt_q == CntW'(Beats - 1));
    complete_o    = beat_hs_i & (cdlast_i | is_final);
    err_early_o   = beat_hs_i & cdlast_i & ~is_final;
    err_missing_o = beat_hs_i & is_final & ~cdlast_i;
    cnt_d         = cnt_q;
    line_d        = line_q;
    if (clear_i) begin
      cnt_d  = '0;
      line_d = '0;
    end else if (beat_hs_i) begin
      for (int k = 0; k < Beats; k++) begin
        if (cnt_q == CntW'(k)) line_d[k*DataWidth +: DataWidth] = cddata_i;
      end
      cnt_d = complete_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/ace_snoop_initiator.sv
// Interconnect-side ACE snoop initiator: issues one AC request, collects CR and optional CD
// data, and reports latencies, timeout and protocol errors. All outputs are registered.
module ace_snoop_initiator
  import ace_snoop_pkg::*;
#(
  parameter int unsigned C_ACE_ADDR_WIDTH = 44,
  parameter int unsigned C_ACE_DATA_WIDTH = 128,
  parameter int unsigned CACHE_LINE_BYTES = 64
) (
  input  logic                                  ace_aclk,
  input  logic                                  ace_areset,
  input  logic                                  i_start,
  input  logic [C_ACE_ADDR_WIDTH-1:0]           i_acaddr,
  input  logic [3:0]                            i_acsnoop,
  input  logic [2:0]                            i_acprot,
  input  logic [31:0]                           i_timeout,
  output logic                                  o_acvalid,
  output logic [C_ACE_ADDR_WIDTH-1:0]           o_acaddr,
  output logic [3:0]                            o_acsnoop,
  output logic [2:0]                            o_acprot,
  input  logic                                  i_acready,
  input  logic                                  i_crvalid,
  input  logic [4:0]                            i_crresp,
  output logic                                  o_crready,
  input  logic                                  i_cdvalid,
  input  logic [C_ACE_DATA_WIDTH-1:0]           i_cddata,
  input  logic                                  i_cdlast,
  output logic                                  o_cdready,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic [31:0]                           o_status,
  output logic [4:0]                            o_crresp_q,
  output logic [31:0]                           o_cr_latency,
  output logic [31:0]                           o_cd_latency,
  output logic [CACHE_LINE_BYTES*8-1:0]         o_cd_line
);

  localparam int unsigned BEATS = CACHE_LINE_BYTES * 8 / C_ACE_DATA_WIDTH;

  state_e                        state_q, state_d;
  logic                          acvalid_q, acvalid_d, crready_q, crready_d, cdready_q, cdready_d;
  logic                          done_q, done_d, busy_q, busy_d;
  logic [C_ACE_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]                    snoop_q, snoop_d;
  logic [2:0]                    prot_q, prot_d;
  logic [STATUS_W-1:0]           status_q, status_d;
  logic [4:0]                    crresp_q, crresp_d;
  logic [31:0]                   cr_lat_q, cr_lat_d, cd_lat_q, cd_lat_d, to_cnt_q, to_cnt_d;
  logic                          ac_hs, cr_hs, cd_hs, start_ok, in_flight, timed_out;
  logic                          cd_complete, cd_err_early, cd_err_missing;

  ace_cd_beat_collector #(
    .DataWidth (C_ACE_DATA_WIDTH),
    .Beats     (BEATS)
  ) u_collector (
    .clk_i         (ace_aclk),
    .rst_i         (ace_areset),
    .clear_i       (start_ok),
    .beat_hs_i     (cd_hs),
    .cddata_i      (i_cddata),
    .cdlast_i      (i_cdlast),
    .line_o        (o_cd_line),
    .complete_o    (cd_complete),
    .err_early_o   (cd_err_early),
    .err_missing_o (cd_err_missing)
  );

  always_comb begin
    state_d   = state_q;
    acvalid_d = acvalid_q;
    crready_d = crready_q;
    cdready_d = cdready_q;
    addr_d    = addr_q;
    snoop_d   = snoop_q;
    prot_d    = prot_q;
    status_d  = status_q;
    crresp_d  = crresp_q;
    cr_lat_d  = cr_lat_q;
    cd_lat_d  = cd_lat_q;
    ac_hs     = acvalid_q & i_acready;
    cr_hs     = crready_q & i_crvalid;
    cd_hs     = cdready_q & i_cdvalid;
    start_ok  = (state_q == S_IDLE) & i_start;
    in_flight = (state_q == S_AC) || (state_q == S_CR) || (state_q == S_CD);
    timed_out = in_flight && (i_timeout != 32'd0) && (to_cnt_q == i_timeout);
    to_cnt_d  = in_flight ? sat_inc(to_cnt_q) : to_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d    = i_acaddr;
          snoop_d   = i_acsnoop;
          prot_d    = i_acprot;
          status_d  = '0;
          crresp_d  = '0;
          cr_lat_d  = '0;
          cd_lat_d  = '0;
          // Counts the S_AC entry cycle as 1 so the abort lands exactly i_timeout cycles later
          to_cnt_d  = 32'd1;
          acvalid_d = 1'b1;
          state_d   = S_AC;
        end
      end
      S_AC: begin
        if (ac_hs) begin
          acvalid_d = 1'b0;
          crready_d = 1'b1;
          state_d   = S_CR;
        end
      end
      S_CR: begin
        cr_lat_d = sat_inc(cr_lat_q);
        if (cr_hs) begin
          crresp_d  = i_crresp;
          crready_d = 1'b0;
          if (i_crresp[CRRESP_DATA_TRANSFER]) begin
            cdready_d = 1'b1;
            state_d   = S_CD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_CD: begin
        cd_lat_d = sat_inc(cd_lat_q);
        if (cd_err_early)   status_d[STATUS_EARLY_LAST]   = 1'b1;
        if (cd_err_missing) status_d[STATUS_MISSING_LAST] = 1'b1;
        if (cd_complete) begin
          cdready_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A handshake that finishes the transaction in the same cycle takes priority over the abort
    if (timed_out && (state_d != S_DONE)) begin
      state_d                  = S_DONE;
      status_d[STATUS_TIMEOUT] = 1'b1;
      acvalid_d                = 1'b0;
      crready_d                = 1'b0;
      cdready_d                = 1'b0;
    end
    if (i_cdvalid && ((state_q == S_IDLE) || (state_q == S_AC))) begin
      status_d[STATUS_UNSOLICITED] = 1'b1;
    end

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge ace_aclk or posedge ace_areset) begin
    if (ace_areset) begin
      state_q   <= S_IDLE;
      acvalid_q <= 1'b0;
      crready_q <= 1'b0;
      cdready_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      snoop_q   <= '0;
      prot_q    <= '0;
      status_q  <= '0;
      crresp_q  <= '0;
      cr_lat_q  <= '0;
      cd_lat_q  <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      acvalid_q <= acvalid_d;
      crready_q <= crready_d;
      cdready_q <= cdready_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      snoop_q   <= snoop_d;
      prot_q    <= prot_d;
      status_q  <= status_d;
      crresp_q  <= crresp_d;
      cr_lat_q  <= cr_lat_d;
      cd_lat_q  <= cd_lat_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign o_acvalid    = acvalid_q;
  assign o_acaddr     = addr_q;
  assign o_acsnoop    = snoop_q;
  assign o_acprot     = prot_q;
  assign o_crready    = crready_q;
  assign o_cdready    = cdready_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_status     = {{(32 - STATUS_W){1'b0}}, status_q};
  assign o_crresp_q   = crresp_q;
  assign o_cr_latency = cr_lat_q;
  assign o_cd_latency = cd_lat_q;

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// Directed-plus-randomized bench for ace_snoop_initiator; expected values come from the
// stimulus timing (handshake cycle offsets, beats sent, cdlast position).
module tb_ace_snoop_initiator;

  localparam int ADDR_W = 44;
  localparam int DATA_W = 128;
  localparam int LINE_B = 64;
  localparam int BEATS  = LINE_B * 8 / DATA_W;

  logic                  ace_aclk = 1'b0;
  logic                  ace_areset = 1'b1;
  logic                  i_start = 1'b0;
  logic [ADDR_W-1:0]     i_acaddr = '0;
  logic [3:0]            i_acsnoop = '0;
  logic [2:0]            i_acprot = '0;
  logic [31:0]           i_timeout = '0;
  logic                  i_acready = 1'b0;
  logic                  i_crvalid = 1'b0;
  logic [4:0]            i_crresp = '0;
  logic                  i_cdvalid = 1'b0;
  logic [DATA_W-1:0]     i_cddata = '0;
  logic                  i_cdlast = 1'b0;
  logic                  o_acvalid, o_crready, o_cdready, o_busy, o_done;
  logic [ADDR_W-1:0]     o_acaddr;
  logic [3:0]            o_acsnoop;
  logic [2:0]            o_acprot;
  logic [31:0]           o_status, o_cr_latency, o_cd_latency;
  logic [4:0]            o_crresp_q;
  logic [LINE_B*8-1:0]   o_cd_line;

  int tests = 0;
  int fails = 0;
  int exp_dones = 0;
  int done_seen = 0;
  logic [3:0] snoops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h8, 4'h9, 4'hD, 4'hE, 4'hF};

  ace_snoop_initiator #(
    .C_ACE_ADDR_WIDTH (ADDR_W),
    .C_ACE_DATA_WIDTH (DATA_W),
    .CACHE_LINE_BYTES (LINE_B)
  ) dut (
    .ace_aclk     (ace_aclk),
    .ace_areset   (ace_areset),
    .i_start      (i_start),
    .i_acaddr     (i_acaddr),
    .i_acsnoop    (i_acsnoop),
    .i_acprot     (i_acprot),
    .i_timeout    (i_timeout),
    .o_acvalid    (o_acvalid),
    .o_acaddr     (o_acaddr),
    .o_acsnoop    (o_acsnoop),
    .o_acprot     (o_acprot),
    .i_acready    (i_acready),
    .i_crvalid    (i_crvalid),
    .i_crresp     (i_crresp),
    .o_crready    (o_crready),
    .i_cdvalid    (i_cdvalid),
    .i_cddata     (i_cddata),
    .i_cdlast     (i_cdlast),
    .o_cdready    (o_cdready),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_status     (o_status),
    .o_crresp_q   (o_crresp_q),
    .o_cr_latency (o_cr_latency),
    .o_cd_latency (o_cd_latency),
    .o_cd_line    (o_cd_line)
  );

  always #5 ace_aclk = ~ace_aclk;

  always @(negedge ace_aclk) if (o_done === 1'b1) done_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ace_aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // last_idx: beat index carrying cdlast; BEATS means no beat carries it
  task automatic run_txn(input logic [3:0] snoop, input logic [ADDR_W-1:0] addr,
                         input logic [2:0] prot, input logic [4:0] crresp, input int ac_delay,
                         input int cr_delay, input int last_idx, input bit unsol,
                         input logic [31:0] timeout);
    logic [DATA_W-1:0] beats [BEATS];
    int                n_stored, cd_lat, g;
    logic [31:0]       exp_status;
    exp_status = '0;
    n_stored   = 0;
    cd_lat     = 0;
    i_timeout  = timeout;
    i_start    = 1'b1;
    i_acaddr   = addr;
    i_acsnoop  = snoop;
    i_acprot   = prot;
    tick();
    i_start   = 1'b0;
    i_acaddr  = {$urandom, $urandom};
    i_acsnoop = 4'($urandom);
    i_acprot  = 3'($urandom);
    check("ac_valid_entry", o_acvalid, 1'b1);
    check("ac_addr_entry", o_acaddr, addr);
    check("busy_entry", o_busy, 1'b1);
    check("status_cleared", o_status, 32'h0);
    check("crresp_cleared", o_crresp_q, 5'h0);
    check("cr_lat_cleared", o_cr_latency, 32'h0);
    check("line_cleared", o_cd_line == '0, 1'b1);
    for (int i = 0; i < ac_delay; i++) begin
      i_cdvalid = unsol && (i == 0);
      tick();
      i_cdvalid = 1'b0;
    end
    if (unsol && ac_delay > 0) exp_status[3] = 1'b1;
    check("ac_valid_hold", o_acvalid, 1'b1);
    check("ac_payload_hold", {o_acaddr, o_acsnoop, o_acprot}, {addr, snoop, prot});
    i_acready = 1'b1;
    tick();
    i_acready = 1'b0;
    check("ac_valid_drop", o_acvalid, 1'b0);
    check("cr_ready_up", o_crready, 1'b1);
    for (int i = 0; i < cr_delay; i++) begin
      i_start  = (i == 0);
      i_acaddr = {$urandom, $urandom};
      tick();
      i_start = 1'b0;
      check("stray_start_ignored", o_acvalid, 1'b0);
    end
    check("cd_ready_low_in_cr", o_cdready, 1'b0);
    i_crvalid = 1'b1;
    i_crresp  = crresp;
    tick();
    i_crvalid = 1'b0;
    i_crresp  = 5'($urandom);
    check("cr_ready_drop", o_crready, 1'b0);
    if (crresp[0]) begin
      check("cd_ready_up", o_cdready, 1'b1);
      for (int k = 0; k < BEATS; k++) begin
        g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) tick();
        beats[k]  = {$urandom, $urandom, $urandom, $urandom};
        i_cdvalid = 1'b1;
        i_cddata  = beats[k];
        i_cdlast  = (k == last_idx);
        tick();
        i_cdvalid = 1'b0;
        i_cdlast  = 1'b0;
        cd_lat   += g + 1;
        n_stored  = k + 1;
        if (k == last_idx) break;
      end
      if (last_idx < BEATS - 1) exp_status[1] = 1'b1;
      if (last_idx >= BEATS) exp_status[2] = 1'b1;
    end else begin
      check("cd_ready_never", o_cdready, 1'b0);
    end
    exp_dones++;
    check("done_pulse", o_done, 1'b1);
    check("busy_in_done", o_busy, 1'b1);
    check("handshakes_idle_in_done", {o_acvalid, o_crready, o_cdready}, 3'b000);
    check("status", o_status, exp_status);
    check("crresp_q", o_crresp_q, crresp);
    check("cr_latency", o_cr_latency, 32'(cr_delay + 1));
    check("cd_latency", o_cd_latency, 32'(cd_lat));
    for (int k = 0; k < BEATS; k++) begin
      check("line_beat", o_cd_line[k*DATA_W +: DATA_W], (k < n_stored) ? beats[k] : '0);
    end
    tick();
    check("done_single", o_done, 1'b0);
    check("idle_after_done", o_busy, 1'b0);
  endtask

  initial begin
    int        r, li;
    logic [4:0] rsp;
    tick();
    check("reset_outputs", {o_acvalid, o_crready, o_cdready, o_busy, o_done}, 5'b0);
    check("reset_status", o_status, 32'h0);
    check("reset_line", o_cd_line == '0, 1'b1);
    tick();
    ace_areset = 1'b0;
    tick();

    // ReadShared with full line, CR three cycles after AC handshake
    run_txn(4'h1, 44'h1000, 3'h2, 5'b00001, 2, 2, BEATS - 1, 1'b0, 32'd0);
    // CleanInvalid, no data
    run_txn(4'h9, 44'h2040, 3'h0, 5'b00000, 1, 0, BEATS - 1, 1'b0, 32'd0);

    // Timeout with AC never accepted
    i_timeout = 32'd10;
    i_start   = 1'b1;
    i_acaddr  = 44'h3000;
    tick();
    i_start = 1'b0;
    check("to_acvalid_entry", o_acvalid, 1'b1);
    for (int i = 1; i < 10; i++) begin
      tick();
      check("to_acvalid_hold", {o_acvalid, o_done}, 2'b10);
    end
    tick();
    exp_dones++;
    check("to_abort", {o_acvalid, o_done}, 2'b01);
    check("to_status", o_status, 32'h1);
    tick();
    check("to_idle", o_busy, 1'b0);
    i_timeout = 32'd0;

    // Early cdlast and missing cdlast
    run_txn(4'h0, 44'h4000, 3'h1, 5'b00001, 0, 1, 1, 1'b0, 32'd0);
    run_txn(4'h7, 44'h5000, 3'h3, 5'b01001, 1, 0, BEATS, 1'b0, 32'd0);

    // Back-to-back with unsolicited CD during S_AC
    run_txn(4'h2, 44'h6000, 3'h4, 5'b00101, 2, 1, BEATS - 1, 1'b1, 32'd0);
    run_txn(4'h3, 44'h6040, 3'h5, 5'b00001, 1, 0, BEATS - 1, 1'b1, 32'd500);

    // Asynchronous reset while in S_CD
    i_start  = 1'b1;
    i_acaddr = 44'h7000;
    tick();
    i_start   = 1'b0;
    i_acready = 1'b1;
    tick();
    i_acready = 1'b0;
    i_crvalid = 1'b1;
    i_crresp  = 5'b00001;
    tick();
    i_crvalid = 1'b0;
    i_cdvalid = 1'b1;
    i_cddata  = {4{32'hA5A5_5A5A}};
    tick();
    i_cdvalid = 1'b0;
    check("cd_before_reset", o_cdready, 1'b1);
    #2 ace_areset = 1'b1;
    #1;
    check("areset_ctrl", {o_acvalid, o_crready, o_cdready, o_busy, o_done}, 5'b0);
    check("areset_data", {o_status, o_crresp_q, o_cr_latency, o_cd_latency}, '0);
    check("areset_line", o_cd_line == '0, 1'b1);
    tick();
    ace_areset = 1'b0;
    tick();
    check("idle_after_reset", o_busy, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 5);
      if (r < 3) li = BEATS - 1;
      else if (r == 3) li = $urandom_range(0, BEATS - 2);
      else li = BEATS;
      rsp = 5'($urandom);
      run_txn(snoops[$urandom_range(0, 9)], {$urandom, $urandom}, 3'($urandom), rsp,
              $urandom_range(0, 3), $urandom_range(0, 3), li, 1'($urandom),
              ($urandom_range(0, 1) == 1) ? 32'd200 : 32'd0);
    end

    tick();
    check("done_pulse_count", 32'(done_seen), 32'(exp_dones));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
